// File: rtl/idli_sqi_resp_m.sv
// idli_sqi_resp_m -- SQI (quad-SPI) SRAM responder.
// Decodes sequential READ (0x03) / WRITE (0x02), 24-bit address (aliased to
// ADDR_W bits), 2 dummy beats on reads, then streams nibbles high-first.
// Optional: define IDLI_SQI_RESP_ERR_EN to get the sticky o_sqr_err output
// (unsupported command or header cut short by deselect).
module idli_sqi_resp_m #(
  parameter int ADDR_W = 8
) (
  input  logic       i_sqr_gck,
  input  logic       i_sqr_rst,
  input  logic       i_sqr_cs,
  input  logic       i_sqr_sck,
  input  logic [3:0] i_sqr_data,
  output logic [3:0] o_sqr_data,
  output logic       o_sqr_oe
`ifdef IDLI_SQI_RESP_ERR_EN
  ,
  output logic       o_sqr_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              lo_ph;   // 0: high nibble is next, 1: low nibble is next
  logic [3:0]        hi_nib;

  // Storage is deliberately not reset: contents survive reset and transactions.
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  logic              beat;
  logic [7:0]        cmd_nx;
  logic [ADDR_W+3:0] addr_sh;
  logic [ADDR_W-1:0] addr_inc;
  logic              wr_en;

  assign beat     = !i_sqr_cs && i_sqr_sck;
  assign cmd_nx   = {cmd[3:0], i_sqr_data};
  assign addr_sh  = {addr, i_sqr_data};   // upper address nibbles fall off the top
  assign addr_inc = addr + 1'b1;          // wraps mod 2^ADDR_W
  assign wr_en    = !i_sqr_rst && beat && (state == S_WDATA) && lo_ph;

  // Protocol sequencer: deselect dominates, otherwise advance only on beats.
  always_ff @(posedge i_sqr_gck) begin
    if (i_sqr_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cmd        <= '0;
      addr       <= '0;
      rd         <= 1'b0;
      lo_ph      <= 1'b0;
      hi_nib     <= '0;
      o_sqr_data <= '0;
      o_sqr_oe   <= 1'b0;
    end else if (i_sqr_cs) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lo_ph    <= 1'b0;
      o_sqr_oe <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_CMD;
          cnt   <= '0;
        end
        S_CMD: if (beat) begin
          cmd <= cmd_nx;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd1) begin
            cnt <= '0;
            if (cmd_nx == 8'h03) begin
              state <= S_ADDR;
              rd    <= 1'b1;
            end else if (cmd_nx == 8'h02) begin
              state <= S_ADDR;
              rd    <= 1'b0;
            end else begin
              state <= S_IGNORE;
            end
          end
        end
        S_ADDR: if (beat) begin
          addr <= addr_sh[ADDR_W-1:0];
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd5) begin
            cnt   <= '0;
            lo_ph <= 1'b0;
            state <= rd ? S_DUMMY : S_WDATA;
          end
        end
        S_DUMMY: if (beat) begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd1) begin
            cnt        <= '0;
            o_sqr_data <= mem[addr][7:4];
            o_sqr_oe   <= 1'b1;
            state      <= S_RDATA;
          end
        end
        S_RDATA: if (beat) begin
          if (!lo_ph) begin
            o_sqr_data <= mem[addr][3:0];
            lo_ph      <= 1'b1;
          end else begin
            addr       <= addr_inc;
            o_sqr_data <= mem[addr_inc][7:4];
            lo_ph      <= 1'b0;
          end
        end
        S_WDATA: if (beat) begin
          if (!lo_ph) begin
            hi_nib <= i_sqr_data;
            lo_ph  <= 1'b1;
          end else begin
            addr  <= addr_inc;
            lo_ph <= 1'b0;
          end
        end
        S_IGNORE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte commit on the low-nibble beat; a lone high nibble never reaches here.
  always_ff @(posedge i_sqr_gck) begin
    if (wr_en) mem[addr] <= {hi_nib, i_sqr_data};
  end

`ifdef IDLI_SQI_RESP_ERR_EN
  // Sticky error: truncated header or unsupported command.
  always_ff @(posedge i_sqr_gck) begin
    if (i_sqr_rst)
      o_sqr_err <= 1'b0;
    else if (i_sqr_cs && (state inside {S_CMD, S_ADDR, S_DUMMY}))
      o_sqr_err <= 1'b1;
    else if (beat && (state == S_CMD) && (cnt == 3'd1) &&
             (cmd_nx != 8'h03) && (cmd_nx != 8'h02))
      o_sqr_err <= 1'b1;
  end
`endif

endmodule
